// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: beat sequencer for a 4-lane registered MAC wrapper.
// Accepts a start command with a beat count and streams 4-pair operand beats
// into the wrapper. On each beat it feeds the wrapper's psum back into the
// wrapper's accumulator input, then returns the final dot product over a
// valid/ready result port.
// Optional feature: define MAC_SEQ_BIAS_EN to add a bias_in port. The bias
// seeds the accumulator in place of the constant zero.
module mac_seq_ctrl #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int CNT_BW  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_BW-1:0]   num_beats,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*BW-1:0]     in_a,
  input  logic [4*BW-1:0]     in_b,
  output logic [4*BW-1:0]     mac_a,
  output logic [4*BW-1:0]     mac_b,
  output logic [PSUM_BW-1:0]  mac_c,
  input  logic [PSUM_BW-1:0]  mac_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PSUM_BW-1:0]  res_data,
  output logic                busy
`ifdef MAC_SEQ_BIAS_EN
  ,
  input  logic [PSUM_BW-1:0]  bias_in
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;

  state_t              state;
  logic [CNT_BW-1:0]   beat_cnt;
  logic [CNT_BW-1:0]   beats_q;
  logic                first_flag;
  logic                fire;
  logic                last_beat;
  logic [PSUM_BW-1:0]  init_val;

`ifdef MAC_SEQ_BIAS_EN
  logic [PSUM_BW-1:0]  init_q;
  logic [PSUM_BW-1:0]  start_init;
  assign init_val   = init_q;
  assign start_init = bias_in;
`else
  logic [PSUM_BW-1:0]  start_init;
  assign init_val   = '0;
  assign start_init = '0;
`endif

  // in_ready is a register that is only high in RUN, so a fire cannot
  // happen in any other state.
  assign fire      = in_valid & in_ready;
  // beats_q is at least 1 whenever RUN is active, so the subtraction
  // cannot underflow. Comparing against the last index, rather than
  // counting up to num_beats, keeps the 2^CNT_BW-1 case within range.
  assign last_beat = (beat_cnt == beats_q - 1'b1);

  // Sequencer FSM: job control, beat counting, and the registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      beats_q    <= '0;
      first_flag <= 1'b1;
      res_valid  <= 1'b0;
      res_data   <= '0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
`ifdef MAC_SEQ_BIAS_EN
      init_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef MAC_SEQ_BIAS_EN
            init_q <= bias_in;
`endif
            if (num_beats != '0) begin
              beats_q    <= num_beats;
              beat_cnt   <= '0;
              first_flag <= 1'b1;
              in_ready   <= 1'b1;
              state      <= RUN;
            end else begin
              res_data  <= start_init;
              res_valid <= 1'b1;
              state     <= RESULT;
            end
          end
        end
        RUN: begin
          if (fire) begin
            beat_cnt   <= beat_cnt + 1'b1;
            first_flag <= 1'b0;
            if (last_beat) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          res_data  <= mac_out;
          res_valid <= 1'b1;
          state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Wrapper drive: operands pass through only on a fire, so a stall adds zero
  // products. The accumulator is seeded on the first beat and chained from
  // mac_out afterwards.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    if (fire) begin
      mac_a = in_a;
      mac_b = in_b;
    end
    if (state == RUN || state == DRAIN) begin
      mac_c = first_flag ? init_val : mac_out;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: self-checking bench for mac_seq_ctrl. It uses a behavioural
// registered MAC wrapper and a reference dot-product model.
// Build with MAC_SEQ_BIAS_EN defined to exercise the bias_in port.
module tb_mac_seq_ctrl;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int CNT_BW  = 8;
`ifdef MAC_SEQ_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [CNT_BW-1:0]  num_beats = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [4*BW-1:0]    in_a = '0;
  logic [4*BW-1:0]    in_b = '0;
  logic [4*BW-1:0]    mac_a;
  logic [4*BW-1:0]    mac_b;
  logic [PSUM_BW-1:0] mac_c;
  logic [PSUM_BW-1:0] mac_out;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [PSUM_BW-1:0] res_data;
  logic               busy;
`ifdef MAC_SEQ_BIAS_EN
  logic [PSUM_BW-1:0] bias_val = '0;
`endif

  int errors = 0;
  int checks = 0;

  logic [4*BW-1:0] beat_a [256];
  logic [4*BW-1:0] beat_b [256];
  int              gap_len [256];

  mac_seq_ctrl #(.BW(BW), .PSUM_BW(PSUM_BW), .CNT_BW(CNT_BW)) dut (
`ifdef MAC_SEQ_BIAS_EN
    .bias_in   (bias_val),
`endif
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_beats (num_beats),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural MAC wrapper: one input register stage, out = c_q + sum(a_q*b_q)
  logic [4*BW-1:0]    a_q = '0;
  logic [4*BW-1:0]    b_q = '0;
  logic [PSUM_BW-1:0] c_q = '0;
  always_ff @(posedge clk) begin
    a_q <= mac_a;
    b_q <= mac_b;
    c_q <= mac_c;
  end
  always_comb begin
    mac_out = c_q;
    for (int i = 0; i < 4; i++)
      mac_out = mac_out + PSUM_BW'(a_q[BW*i +: BW]) * PSUM_BW'(b_q[BW*i +: BW]);
  end

  // Reference: init plus the dot products of all beats, wrapped to PSUM_BW bits
  function automatic logic [PSUM_BW-1:0] ref_result(input int nb, input logic [PSUM_BW-1:0] init);
    int acc;
    acc = int'(init);
    for (int k = 0; k < nb; k++)
      for (int i = 0; i < 4; i++)
        acc = acc + int'(beat_a[k][BW*i +: BW]) * int'(beat_b[k][BW*i +: BW]);
    return acc[PSUM_BW-1:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits for res_valid and counts the cycles spent waiting
  task automatic wait_result(output int lat, output bit timeout);
    lat = 0;
    while (!res_valid && lat < 40) begin
      tick;
      lat++;
    end
    timeout = !res_valid;
  endtask

  // Drives one job from beat_a/beat_b/gap_len. Stops once the result is valid.
  task automatic drive_job(input int nb, input logic [PSUM_BW-1:0] bias,
                           output int lat, output bit timeout);
    int guard;
`ifdef MAC_SEQ_BIAS_EN
    bias_val = bias;
`else
    if (bias != 0) $display("[TB] note: bias %0d unused in this build", bias);
`endif
    start = 1'b1;
    num_beats = nb[CNT_BW-1:0];
    tick;
    start = 1'b0;
    timeout = 1'b0;
    for (int k = 0; k < nb; k++) begin
      in_valid = 1'b0;
      repeat (gap_len[k]) tick;
      in_valid = 1'b1;
      in_a = beat_a[k];
      in_b = beat_b[k];
      guard = 0;
      while (!in_ready && guard < 40) begin
        tick;
        guard++;
      end
      if (!in_ready) timeout = 1'b1;
      tick;
      in_valid = 1'b0;
    end
    in_a = '0;
    in_b = '0;
    begin
      bit to2;
      wait_result(lat, to2);
      timeout = timeout | to2;
    end
  endtask

  task automatic consume;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask

  task automatic load_basic;
    beat_a[0] = 16'h4321; beat_b[0] = 16'h1111; gap_len[0] = 0;
    beat_a[1] = 16'h2222; beat_b[1] = 16'h3333; gap_len[1] = 0;
  endtask

  task automatic applyStimulus_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    applyStimulus_reset;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got=%b want=0", res_valid); end
    checks++; if (res_data !== '0) begin errors++; $display("[TB] FAIL reset_res_data got=%0d want=0", res_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (mac_c !== '0) begin errors++; $display("[TB] FAIL reset_mac_c got=%0d want=0", mac_c); end
  endtask

  task automatic test_basic;
    int lat; bit to;
    load_basic;
    drive_job(2, 16'd0, lat, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout got=timeout want=res_valid"); end
    checks++; if (res_data !== 16'd34) begin errors++; $display("[TB] FAIL basic_data got=%0d want=34", res_data); end
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL basic_latency got=%0d want=1 (cycle after DRAIN)", lat); end
    consume;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got busy=%b res_valid=%b want 0/0", busy, res_valid); end
  endtask

  task automatic test_stall;
    int lat; bit to;
    load_basic;
    start = 1'b1; num_beats = 8'd2;
    tick;
    start = 1'b0;
    in_valid = 1'b1; in_a = beat_a[0]; in_b = beat_b[0];
    tick;
    for (int g = 0; g < 3; g++) begin
      in_valid = 1'b0; in_a = 16'hFFFF; in_b = 16'hFFFF;
      #1;
      checks++; if (mac_a !== '0 || mac_b !== '0) begin errors++; $display("[TB] FAIL stall_zero_ops got a=%h b=%h want 0/0", mac_a, mac_b); end
      tick;
    end
    in_valid = 1'b1; in_a = beat_a[1]; in_b = beat_b[1];
    tick;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    wait_result(lat, to);
    checks++; if (to || res_data !== 16'd34) begin errors++; $display("[TB] FAIL stall_data got=%0d timeout=%0d want=34", res_data, to); end
    consume;
  endtask

  task automatic test_backpressure;
    int lat; bit to;
    load_basic;
    drive_job(2, 16'd0, lat, to);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2); num_beats = 8'd1;
      checks++; if (res_valid !== 1'b1 || res_data !== 16'd34 || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_hold got valid=%b data=%0d busy=%b want 1/34/1", res_valid, res_data, busy);
      end
      tick;
    end
    start = 1'b0;
    consume;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release got valid=%b busy=%b in_ready=%b want 0/0/0", res_valid, busy, in_ready);
    end
  endtask

  task automatic test_zero_len;
    int lat; bit to;
    logic [PSUM_BW-1:0] exp_v;
    exp_v = BIAS_ON ? 16'd100 : 16'd0;
    drive_job(0, 16'd100, lat, to);
    checks++; if (to || lat !== 0) begin errors++; $display("[TB] FAIL zero_latency got=%0d timeout=%0d want=0", lat, to); end
    checks++; if (res_data !== exp_v) begin errors++; $display("[TB] FAIL zero_data got=%0d want=%0d", res_data, exp_v); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_in_ready got=%b want=0", in_ready); end
    consume;
  endtask

  task automatic test_mid_reset;
    int lat; bit to;
    start = 1'b1; num_beats = 8'd3;
    tick;
    start = 1'b0;
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321;
    tick;
    in_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_idle got in_ready=%b valid=%b busy=%b want 0/0/0", in_ready, res_valid, busy);
    end
    beat_a[0] = 16'h5555; beat_b[0] = 16'h1111; gap_len[0] = 0;
    drive_job(1, 16'd0, lat, to);
    checks++; if (to || res_data !== 16'd20) begin errors++; $display("[TB] FAIL midreset_next_job got=%0d timeout=%0d want=20", res_data, to); end
    consume;
  endtask

  task automatic test_bias;
    int lat; bit to;
    logic [PSUM_BW-1:0] exp_v;
    exp_v = BIAS_ON ? 16'd134 : 16'd34;
    load_basic;
    drive_job(2, 16'd100, lat, to);
    checks++; if (to || res_data !== exp_v) begin errors++; $display("[TB] FAIL bias_data got=%0d timeout=%0d want=%0d", res_data, to, exp_v); end
    consume;
  endtask

  task automatic test_random;
    int lat; bit to; int nb; int hold;
    logic [PSUM_BW-1:0] bias, exp_v;
    for (int j = 0; j < 10; j++) begin
      nb = $urandom_range(1, 10);
      for (int k = 0; k < nb; k++) begin
        beat_a[k] = 16'($urandom);
        beat_b[k] = 16'($urandom);
        gap_len[k] = $urandom_range(0, 2);
      end
      bias = 16'($urandom);
      exp_v = ref_result(nb, BIAS_ON ? bias : 16'd0);
      drive_job(nb, bias, lat, to);
      checks++; if (to || lat !== 1) begin errors++; $display("[TB] FAIL rand_latency job=%0d got=%0d timeout=%0d want=1", j, lat, to); end
      hold = $urandom_range(0, 3);
      repeat (hold) tick;
      checks++; if (res_data !== exp_v) begin errors++; $display("[TB] FAIL rand_data job=%0d nb=%0d got=%0d want=%0d", j, nb, res_data, exp_v); end
      consume;
    end
  endtask

  task automatic test_max_beats;
    int lat; bit to;
    logic [PSUM_BW-1:0] exp_v;
    for (int k = 0; k < 255; k++) begin
      beat_a[k] = 16'($urandom);
      beat_b[k] = 16'($urandom);
      gap_len[k] = 0;
    end
    exp_v = ref_result(255, 16'd0);
    drive_job(255, 16'd0, lat, to);
    checks++; if (to || res_data !== exp_v) begin errors++; $display("[TB] FAIL max_beats got=%0d timeout=%0d want=%0d", res_data, to, exp_v); end
    consume;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_backpressure;
    test_zero_len;
    test_mid_reset;
    test_bias;
    test_random;
    test_max_beats;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
